// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, counter sizing.
// Optional MADD/MADDU support is controlled by the MDU_MADD_EN macro in mdu and mdu_arith.
package mdu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MADD  = 3'd6;
    localparam logic [2:0] MDU_MADDU = 3'd7;

    // Operands captured at the start edge and held for the whole operation.
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } mdu_req_t;

    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        return $clog2((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage (master) and the multiply/divide unit (slave).
// HI/LO are always readable; busy tells the pipeline to hold MDU ops and MFHI/MFLO.
interface mdu_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, mdu_op, A, B, input busy, HI, LO);
    modport slave  (input start, mdu_op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mdu_arith.sv
// Purpose: combinational 64-bit {HI,LO} result for the latched op, plus divide-by-zero flag.
// Latency: purely combinational; the top samples it on the last busy cycle.
// Backpressure: none; MADD/MADDU accumulate only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] bm_safe;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;

    // Low 64 bits of the sign-extended product equal the true signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign a_mag   = a[31] ? (~a + 32'd1) : a;
    assign b_mag   = b[31] ? (~b + 32'd1) : b;
    assign b_safe  = (b == 32'd0) ? 32'd1 : b;
    assign bm_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign sq_mag  = a_mag / bm_safe;
    assign sr_mag  = a_mag % bm_safe;
    assign sq      = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign sr      = a[31] ? (~sr_mag + 32'd1) : sr_mag;

    assign div_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);

    always_comb begin
        res = {hi, lo};
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   if (!div_zero) res = {sr, sq};
            MDU_DIVU:  if (!div_zero) res = {a % b_safe, a / b_safe};
`ifdef MDU_MADD_EN
            MDU_MADD:  res = {hi, lo} + prod_s;
            MDU_MADDU: res = {hi, lo} + prod_u;
`endif
            default:   res = {hi, lo};
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Purpose: multi-cycle MULT/DIV unit with HI/LO; MTHI/MTLO write in one edge. Macro MDU_MADD_EN adds MADD/MADDU.
// Latency: busy for MULT_CYCLES or DIV_CYCLES after the start edge; HI/LO and busy=0 appear together.
// Backpressure: busy stalls the pipeline; start while busy or with an unknown op is dropped.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    mdu_req_t         req_q,   req_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    logic [63:0]      arith_res;
    logic             arith_div_zero;

    function automatic logic is_long_op(input logic [2:0] op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU:                    return 1'b1;
`endif
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    mdu_arith u_arith (
        .op       (req_q.op),
        .a        (req_q.a),
        .b        (req_q.b),
        .hi       (hi_q),
        .lo       (lo_q),
        .res      (arith_res),
        .div_zero (arith_div_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_long_op(bus.mdu_op)) begin
                        req_d   = '{op: bus.mdu_op, a: bus.A, b: bus.B};
                        cnt_d   = is_div_op(bus.mdu_op) ? DIV_LAST : MUL_LAST;
                        state_d = ST_RUN;
                    end else if (bus.mdu_op == MDU_MTHI) begin
                        hi_d = bus.A;
                    end else if (bus.mdu_op == MDU_MTLO) begin
                        lo_d = bus.A;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    // A zero divisor still burns the full latency but leaves HI/LO alone.
                    if (!arith_div_zero) begin
                        hi_d = arith_res[63:32];
                        lo_d = arith_res[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboarded bench for mdu: directed corner cases plus random ops against a plain-arithmetic HI/LO model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_if m();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] ohi;
        logic [31:0] olo;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    bit          sb_skip = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: HI/LO as plain 64-bit arithmetic, no notion of cycles beyond latency.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit long_op, output int cyc);
        longint      p_s;
        logic [63:0] p_u;
        logic [63:0] acc;
        int          sa;
        int          sbv;
        p_s = longint'($signed(a)) * longint'($signed(b));
        p_u = {32'd0, a} * {32'd0, b};
        acc = {mhi, mlo};
        sa  = a;
        sbv = b;
        long_op = 1'b0;
        cyc     = 0;
        case (op)
            MDU_MULT:  begin {mhi, mlo} = p_s; long_op = 1'b1; cyc = MC; end
            MDU_MULTU: begin {mhi, mlo} = p_u; long_op = 1'b1; cyc = MC; end
            MDU_DIV: begin
                long_op = 1'b1; cyc = DC;
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        mlo = 32'h8000_0000; mhi = 32'd0;
                    end else begin
                        mlo = sa / sbv; mhi = sa % sbv;
                    end
                end
            end
            MDU_DIVU: begin
                long_op = 1'b1; cyc = DC;
                if (b != 0) begin mlo = a / b; mhi = a % b; end
            end
            MDU_MTHI: mhi = a;
            MDU_MTLO: mlo = a;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin {mhi, mlo} = acc + p_s; long_op = 1'b1; cyc = MC; end
            MDU_MADDU: begin {mhi, mlo} = acc + p_u; long_op = 1'b1; cyc = MC; end
`endif
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (m.busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", m.busy, n);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        bit   long_op;
        int   cyc;
        wait_idle();
        e.ohi = mhi;
        e.olo = mlo;
        m.start = 1'b1; m.mdu_op = op; m.A = a; m.B = b;
        @(posedge clk);
        #1 m.start = 1'b0;
        model(op, a, b, long_op, cyc);
        if (long_op) begin
            e.hi = mhi; e.lo = mlo; e.cyc = cyc;
            if (push) sb_q.push_back(e);
        end else begin
            @(negedge clk);
            chk("short_busy", 64'(m.busy), 64'd0);
            chk("short_HI", 64'(m.HI), 64'(mhi));
            chk("short_LO", 64'(m.LO), 64'(mlo));
        end
    endtask

    // Monitor: counts busy cycles, holds HI/LO steady while busy, scores each completion.
    initial begin : monitor
        int   run;
        logic prev;
        exp_t e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (m.busy === 1'b1) begin
                run++;
                if (!sb_skip && sb_q.size() > 0) begin
                    chk("hold_HI", 64'(m.HI), 64'(sb_q[0].ohi));
                    chk("hold_LO", 64'(m.LO), 64'(sb_q[0].olo));
                end
            end else if (prev === 1'b1) begin
                if (sb_skip) begin
                    sb_skip = 1'b0;
                end else if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: completion after %0d busy cycles, required none", run);
                end else begin
                    e = sb_q.pop_front();
                    chk("busy_cycles", 64'(run), 64'(e.cyc));
                    chk("done_HI", 64'(m.HI), 64'(e.hi));
                    chk("done_LO", 64'(m.LO), 64'(e.lo));
                end
                run = 0;
            end else begin
                run = 0;
            end
            prev = m.busy;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        int          n;
        m.start = 1'b0; m.mdu_op = '0; m.A = '0; m.B = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(m.busy), 64'd0);
        chk("reset_HI", 64'(m.HI), 64'd0);
        chk("reset_LO", 64'(m.LO), 64'd0);
        rst_n = 1'b1;

        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_idle();
        chk("mult_HI", 64'(m.HI), 64'hFFFF_FFFF);
        chk("mult_LO", 64'(m.LO), 64'hFFFF_FFFA);

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        chk("multu_HI", 64'(m.HI), 64'hFFFF_FFFE);
        chk("multu_LO", 64'(m.LO), 64'h0000_0001);

        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        chk("div_HI", 64'(m.HI), 64'hFFFF_FFFF);
        chk("div_LO", 64'(m.LO), 64'hFFFF_FFFD);

        issue(MDU_DIVU, 32'd7, 32'd2, 1'b1);
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        chk("divovf_HI", 64'(m.HI), 64'd0);
        chk("divovf_LO", 64'(m.LO), 64'h8000_0000);

        issue(MDU_MTHI, 32'h1234, 32'd0, 1'b1);
        issue(MDU_MTLO, 32'h5678, 32'd0, 1'b1);
        issue(MDU_DIVU, 32'd99, 32'd0, 1'b1);
        wait_idle();
        chk("div0_HI", 64'(m.HI), 64'h1234);
        chk("div0_LO", 64'(m.LO), 64'h5678);

        // A MULT pulsed mid-divide must not disturb the running divide.
        issue(MDU_DIV, 32'd100, 32'd7, 1'b1);
        repeat (2) @(negedge clk);
        m.start = 1'b1; m.mdu_op = MDU_MULT; m.A = 32'd3; m.B = 32'd3;
        @(posedge clk);
        #1 m.start = 1'b0;
        wait_idle();
        chk("ignore_HI", 64'(m.HI), 64'd2);
        chk("ignore_LO", 64'(m.LO), 64'd14);

        issue(MDU_MTHI, 32'd0, 32'd0, 1'b1);
        issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b1);
        issue(MDU_MADDU, 32'd1, 32'd1, 1'b1);
        wait_idle();
`ifdef MDU_MADD_EN
        chk("maddu_HI", 64'(m.HI), 64'd1);
        chk("maddu_LO", 64'(m.LO), 64'd0);
`else
        chk("maddu_HI", 64'(m.HI), 64'd0);
        chk("maddu_LO", 64'(m.LO), 64'hFFFF_FFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ra = $urandom;
                1: ra = 32'($urandom_range(0, 20));
                2: ra = 32'h8000_0000;
                default: ra = 32'hFFFF_FFFF;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb, 1'b1);
        end

        // Reset during a divide aborts it and clears HI/LO immediately.
        wait_idle();
        sb_skip = 1'b1;
        issue(MDU_DIV, 32'd50, 32'd3, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(m.busy), 64'd0);
        chk("abort_HI", 64'(m.HI), 64'd0);
        chk("abort_LO", 64'(m.LO), 64'd0);
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;

        issue(MDU_MULTU, 32'd6, 32'd7, 1'b1);
        wait_idle();
        chk("post_reset_LO", 64'(m.LO), 64'd42);

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
